// File: rtl/dma_ram_pkg.sv
// Shared types and constants for the buffer-RAM port arbiter and its read tag pipeline.
package dma_ram_pkg;

    localparam int LAT_LOW  = 1;
    localparam int LAT_HIGH = 2;

    localparam logic REQ_DMA  = 1'b0;
    localparam logic REQ_HOST = 1'b1;

    typedef struct packed {
        logic valid;
        logic id;
    } rd_tag_t;

    function automatic bit lat_legal(input int lat);
        return (lat == LAT_LOW) || (lat == LAT_HIGH);
    endfunction

endpackage

// File: rtl/dpram_rd_tag_pipe.sv
// Fixed-depth shift register carrying {valid, id} of each issued read until its RAM data returns.
module dpram_rd_tag_pipe
    import dma_ram_pkg::*;
#(
    parameter int DEPTH = 1
) (
    input  logic    clk,
    input  logic    rst_n,
    input  rd_tag_t tag_i,
    output rd_tag_t tag_o
);

    rd_tag_t [DEPTH-1:0] stage_q;

    // Never stalls: RAM read data cannot be held, so tags advance every cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stage_q <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int i = 1; i < DEPTH; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/dpram_port_arbiter.sv
// Round-robin arbiter sharing one buffer-RAM port between the DMA engine (m0) and host access (m1).
module dpram_port_arbiter
    import dma_ram_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int RD_LATENCY = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  arb_en,
    input  logic                  m0_valid,
    output logic                  m0_ready,
    input  logic                  m0_we,
    input  logic [ADDR_WIDTH-1:0] m0_addr,
    input  logic [DATA_WIDTH-1:0] m0_wdata,
    output logic                  m0_rvalid,
    output logic [DATA_WIDTH-1:0] m0_rdata,
    input  logic                  m1_valid,
    output logic                  m1_ready,
    input  logic                  m1_we,
    input  logic [ADDR_WIDTH-1:0] m1_addr,
    input  logic [DATA_WIDTH-1:0] m1_wdata,
    output logic                  m1_rvalid,
    output logic [DATA_WIDTH-1:0] m1_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    generate
        if (!lat_legal(RD_LATENCY)) begin : g_bad_latency
            $error("dpram_port_arbiter: RD_LATENCY must be 1 or 2");
        end
    endgenerate

    logic    rr_ptr_q;
    logic    rr_ptr_d;
    logic    grant0;
    logic    grant1;
    rd_tag_t tag_in;
    rd_tag_t tag_out;

    // Grants are qualified by rst_n so ready and the RAM strobes are quiet while reset is held.
    always_comb begin
        grant0 = rst_n & arb_en & m0_valid & (~m1_valid | (rr_ptr_q == REQ_DMA));
        grant1 = rst_n & arb_en & m1_valid & (~m0_valid | (rr_ptr_q == REQ_HOST));
    end

    assign m0_ready = grant0;
    assign m1_ready = grant1;

    always_comb begin
        rr_ptr_d = rr_ptr_q;
        if (grant0) begin
            rr_ptr_d = REQ_HOST;
        end else if (grant1) begin
            rr_ptr_d = REQ_DMA;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rr_ptr_q <= REQ_DMA;
        end else begin
            rr_ptr_q <= rr_ptr_d;
        end
    end

    always_comb begin
        ram_en   = 1'b0;
        ram_we   = 1'b0;
        ram_addr = '0;
        ram_din  = '0;
        if (grant0) begin
            ram_en   = 1'b1;
            ram_we   = m0_we;
            ram_addr = m0_addr;
            ram_din  = m0_wdata;
        end else if (grant1) begin
            ram_en   = 1'b1;
            ram_we   = m1_we;
            ram_addr = m1_addr;
            ram_din  = m1_wdata;
        end
    end

    always_comb begin
        tag_in.valid = (grant0 | grant1) & ~ram_we;
        tag_in.id    = grant1;
    end

    dpram_rd_tag_pipe #(
        .DEPTH (RD_LATENCY)
    ) u_tag_pipe (
        .clk   (clk),
        .rst_n (rst_n),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

    assign m0_rvalid = tag_out.valid & (tag_out.id == REQ_DMA);
    assign m1_rvalid = tag_out.valid & (tag_out.id == REQ_HOST);
    assign m0_rdata  = m0_rvalid ? ram_dout : '0;
    assign m1_rdata  = m1_rvalid ? ram_dout : '0;

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Drives two arbiters (read latency 1 and 2) with identical commands and scoreboards both.
module tb_dpram_port_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        arb_en;
    logic        m0_valid, m0_we, m1_valid, m1_we;
    logic [7:0]  m0_addr, m1_addr;
    logic [31:0] m0_wdata, m1_wdata;

    logic        a_m0_ready, a_m1_ready, a_m0_rvalid, a_m1_rvalid;
    logic [31:0] a_m0_rdata, a_m1_rdata;
    logic        a_ram_en, a_ram_we;
    logic [7:0]  a_ram_addr;
    logic [31:0] a_ram_din, a_ram_dout;

    logic        b_m0_ready, b_m1_ready, b_m0_rvalid, b_m1_rvalid;
    logic [31:0] b_m0_rdata, b_m1_rdata;
    logic        b_ram_en, b_ram_we;
    logic [7:0]  b_ram_addr;
    logic [31:0] b_ram_din, b_ram_dout;

    always #5 clk = ~clk;

    dpram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(1)) u_dut_l1 (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .m0_valid(m0_valid), .m0_ready(a_m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rvalid(a_m0_rvalid), .m0_rdata(a_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(a_m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rvalid(a_m1_rvalid), .m1_rdata(a_m1_rdata),
        .ram_en(a_ram_en), .ram_we(a_ram_we), .ram_addr(a_ram_addr),
        .ram_din(a_ram_din), .ram_dout(a_ram_dout)
    );

    dpram_port_arbiter #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .RD_LATENCY(2)) u_dut_l2 (
        .clk(clk), .rst_n(rst_n), .arb_en(arb_en),
        .m0_valid(m0_valid), .m0_ready(b_m0_ready), .m0_we(m0_we), .m0_addr(m0_addr),
        .m0_wdata(m0_wdata), .m0_rvalid(b_m0_rvalid), .m0_rdata(b_m0_rdata),
        .m1_valid(m1_valid), .m1_ready(b_m1_ready), .m1_we(m1_we), .m1_addr(m1_addr),
        .m1_wdata(m1_wdata), .m1_rvalid(b_m1_rvalid), .m1_rdata(b_m1_rdata),
        .ram_en(b_ram_en), .ram_we(b_ram_we), .ram_addr(b_ram_addr),
        .ram_din(b_ram_din), .ram_dout(b_ram_dout)
    );

    function automatic logic [31:0] init_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        if (i == 16) return 32'hDEAD_BEEF;
        return {b, ~b, 8'h5A, 8'(i * 3)};
    endfunction

    // Write-first RAM models; memories are loaded on the first clock (reset holds the port idle then).
    logic [31:0] mem_a [256];
    logic [31:0] mem_b [256];
    logic [31:0] dq_a, dq_b, dq2_b;
    logic        init_done = 1'b0;

    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) begin
                mem_a[i] <= init_val(i);
                mem_b[i] <= init_val(i);
            end
            init_done <= 1'b1;
        end else begin
            if (a_ram_en) begin
                if (a_ram_we) begin
                    mem_a[a_ram_addr] <= a_ram_din;
                    dq_a <= a_ram_din;
                end else begin
                    dq_a <= mem_a[a_ram_addr];
                end
            end
            if (b_ram_en) begin
                if (b_ram_we) begin
                    mem_b[b_ram_addr] <= b_ram_din;
                    dq_b <= b_ram_din;
                end else begin
                    dq_b <= mem_b[b_ram_addr];
                end
            end
            dq2_b <= dq_b;
        end
    end

    assign a_ram_dout = dq_a;
    assign b_ram_dout = dq2_b;

    // Scoreboard
    typedef struct {
        logic        id;
        logic [7:0]  addr;
        logic [31:0] data;
        int          due;
    } sb_t;

    sb_t         qa[$];
    sb_t         qb[$];
    logic [31:0] ref_mem [256];
    int          cyc = 0;
    logic        exp_rr = 1'b0;
    logic        exp_g0 = 1'b0;
    logic        exp_g1 = 1'b0;
    int          n_checks = 0;
    int          n_errors = 0;

    task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    task automatic check_rsp(input string name, input bit has, input sb_t e,
                             input logic rv0, input logic rv1,
                             input logic [31:0] rd0, input logic [31:0] rd1);
        logic        erv0, erv1;
        logic [31:0] erd0, erd1;
        erv0 = has && (e.id == 1'b0);
        erv1 = has && (e.id == 1'b1);
        erd0 = erv0 ? e.data : 32'h0;
        erd1 = erv1 ? e.data : 32'h0;
        check_val({name, "_rvalid"}, {62'h0, rv0, rv1}, {62'h0, erv0, erv1});
        check_val({name, "_rdata"}, {rd0, rd1}, {erd0, erd1});
        if (has)
            $display("rsp %s m%0d addr=%h data=%h", name, e.id, e.addr, rv0 ? rd0 : rd1);
    endtask

    initial begin
        for (int i = 0; i < 256; i++) ref_mem[i] = init_val(i);
    end

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            exp_rr <= 1'b0;
            qa.delete();
            qb.delete();
        end else if (exp_g0) begin
            exp_rr <= 1'b1;
        end else if (exp_g1) begin
            exp_rr <= 1'b0;
        end
    end

    always @(negedge clk) begin
        logic        e_we;
        logic [7:0]  e_addr;
        logic [31:0] e_din;
        sb_t         ea, eb, ne;
        bit          ha, hb;

        exp_g0 = rst_n & arb_en & m0_valid & (~m1_valid | (exp_rr == 1'b0));
        exp_g1 = rst_n & arb_en & m1_valid & (~m0_valid | (exp_rr == 1'b1));
        e_we   = exp_g0 ? m0_we    : (exp_g1 ? m1_we    : 1'b0);
        e_addr = exp_g0 ? m0_addr  : (exp_g1 ? m1_addr  : 8'h0);
        e_din  = exp_g0 ? m0_wdata : (exp_g1 ? m1_wdata : 32'h0);

        check_val("ready", {60'h0, a_m0_ready, a_m1_ready, b_m0_ready, b_m1_ready},
                  {60'h0, exp_g0, exp_g1, exp_g0, exp_g1});
        check_val("ram_bus_l1", {22'h0, a_ram_en, a_ram_we, a_ram_addr, a_ram_din},
                  {22'h0, exp_g0 | exp_g1, e_we, e_addr, e_din});
        check_val("ram_bus_l2", {22'h0, b_ram_en, b_ram_we, b_ram_addr, b_ram_din},
                  {22'h0, exp_g0 | exp_g1, e_we, e_addr, e_din});

        ha = (qa.size() > 0) && (qa[0].due == cyc);
        ea = '{id: 1'b0, addr: 8'h0, data: 32'h0, due: 0};
        if (ha) ea = qa.pop_front();
        check_rsp("l1", ha, ea, a_m0_rvalid, a_m1_rvalid, a_m0_rdata, a_m1_rdata);

        hb = (qb.size() > 0) && (qb[0].due == cyc);
        eb = '{id: 1'b0, addr: 8'h0, data: 32'h0, due: 0};
        if (hb) eb = qb.pop_front();
        check_rsp("l2", hb, eb, b_m0_rvalid, b_m1_rvalid, b_m0_rdata, b_m1_rdata);

        if (exp_g0 | exp_g1) begin
            if (e_we) begin
                ref_mem[e_addr] = e_din;
                $display("wr m%0d addr=%h data=%h", exp_g1, e_addr, e_din);
            end else begin
                ne = '{id: exp_g1, addr: e_addr, data: ref_mem[e_addr], due: cyc + 1};
                qa.push_back(ne);
                ne.due = cyc + 2;
                qb.push_back(ne);
            end
        end
    end

    task automatic drive(input logic v0, input logic we0, input logic [7:0] a0, input logic [31:0] d0,
                         input logic v1, input logic we1, input logic [7:0] a1, input logic [31:0] d1);
        m0_valid = v0; m0_we = we0; m0_addr = a0; m0_wdata = d0;
        m1_valid = v1; m1_we = we1; m1_addr = a1; m1_wdata = d1;
        @(posedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(0, 0, 8'h0, 32'h0, 0, 0, 8'h0, 32'h0);
    endtask

    initial begin
        rst_n  = 1'b0;
        arb_en = 1'b1;
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 8'h10; m0_wdata = 32'h0;
        m1_valid = 1'b0; m1_we = 1'b0; m1_addr = 8'h0;  m1_wdata = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // First cycle out of reset: m0 wins and reads 0xDEADBEEF
        drive(1, 0, 8'h10, 32'h0, 0, 0, 8'h0, 32'h0);
        idle(2);
        drive(0, 0, 8'h0, 32'h0, 1, 0, 8'h03, 32'h0);

        // Continuous contention: grants alternate 0,1,0,1
        for (int i = 0; i < 4; i++) drive(1, 0, 8'h01, 32'h0, 1, 0, 8'h02, 32'h0);
        idle(1);

        // Write then read-back on the following cycle
        drive(0, 0, 8'h0, 32'h0, 1, 1, 8'h20, 32'h0000_55AA);
        drive(0, 0, 8'h0, 32'h0, 1, 0, 8'h20, 32'h0);
        idle(3);

        // Grant gating with a read in flight
        drive(1, 0, 8'h30, 32'h0, 0, 0, 8'h0, 32'h0);
        arb_en = 1'b0;
        for (int i = 0; i < 3; i++) drive(1, 0, 8'h31, 32'h0, 1, 0, 8'h32, 32'h0);
        arb_en = 1'b1;
        idle(2);

        // Random traffic over a small address window to exercise write/read hazards
        for (int i = 0; i < 60; i++) begin
            arb_en = ($urandom_range(0, 7) != 0);
            drive($urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 15)), $urandom,
                  $urandom_range(0, 1), $urandom_range(0, 1), 8'($urandom_range(0, 15)), $urandom);
        end
        arb_en = 1'b1;
        idle(3);

        // Reset one cycle after a read grant: that read must never return
        drive(1, 0, 8'h10, 32'h0, 0, 0, 8'h0, 32'h0);
        m0_valid = 1'b0;
        rst_n    = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        idle(4);

        for (int i = 0; i < 10 && (qa.size() > 0 || qb.size() > 0); i++) idle(1);
        check_val("drain_l1", 64'(qa.size()), 64'h0);
        check_val("drain_l2", 64'(qb.size()), 64'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
